// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op-code map, op classes,
// controller states and the op-code classification helper.
package alu_pkg;

    localparam int OP_CODE_W = 6;

    localparam logic [OP_CODE_W-1:0] OP_NOP    = 6'd0;
    localparam logic [OP_CODE_W-1:0] OP_LB     = 6'd1;
    localparam logic [OP_CODE_W-1:0] OP_LH     = 6'd2;
    localparam logic [OP_CODE_W-1:0] OP_LW     = 6'd3;
    localparam logic [OP_CODE_W-1:0] OP_LBU    = 6'd4;
    localparam logic [OP_CODE_W-1:0] OP_LHU    = 6'd5;
    localparam logic [OP_CODE_W-1:0] OP_SB     = 6'd6;
    localparam logic [OP_CODE_W-1:0] OP_SH     = 6'd7;
    localparam logic [OP_CODE_W-1:0] OP_ADDI   = 6'd8;
    localparam logic [OP_CODE_W-1:0] OP_SLTI   = 6'd9;
    localparam logic [OP_CODE_W-1:0] OP_SLTIU  = 6'd10;
    localparam logic [OP_CODE_W-1:0] OP_XORI   = 6'd11;
    localparam logic [OP_CODE_W-1:0] OP_ORI    = 6'd12;
    localparam logic [OP_CODE_W-1:0] OP_ANDI   = 6'd13;
    localparam logic [OP_CODE_W-1:0] OP_SLLI   = 6'd14;
    localparam logic [OP_CODE_W-1:0] OP_SRLI   = 6'd15;
    localparam logic [OP_CODE_W-1:0] OP_SRAI   = 6'd16;
    localparam logic [OP_CODE_W-1:0] OP_SW     = 6'd17;
    localparam logic [OP_CODE_W-1:0] OP_LUI    = 6'd18;
    localparam logic [OP_CODE_W-1:0] OP_AUIPC  = 6'd19;
    localparam logic [OP_CODE_W-1:0] OP_FENCE  = 6'd20;
    localparam logic [OP_CODE_W-1:0] OP_ECALL  = 6'd21;
    localparam logic [OP_CODE_W-1:0] OP_ADD    = 6'd22;
    localparam logic [OP_CODE_W-1:0] OP_SUB    = 6'd23;
    localparam logic [OP_CODE_W-1:0] OP_SLL    = 6'd24;
    localparam logic [OP_CODE_W-1:0] OP_SLT    = 6'd25;
    localparam logic [OP_CODE_W-1:0] OP_SLTU   = 6'd26;
    localparam logic [OP_CODE_W-1:0] OP_XOR    = 6'd27;
    localparam logic [OP_CODE_W-1:0] OP_SRL    = 6'd28;
    localparam logic [OP_CODE_W-1:0] OP_SRA    = 6'd29;
    localparam logic [OP_CODE_W-1:0] OP_OR     = 6'd30;
    localparam logic [OP_CODE_W-1:0] OP_AND    = 6'd31;
    localparam logic [OP_CODE_W-1:0] OP_EBREAK = 6'd32;
    localparam logic [OP_CODE_W-1:0] OP_BEQ    = 6'd33;
    localparam logic [OP_CODE_W-1:0] OP_BNE    = 6'd34;
    localparam logic [OP_CODE_W-1:0] OP_BLT    = 6'd35;
    localparam logic [OP_CODE_W-1:0] OP_BGE    = 6'd36;
    localparam logic [OP_CODE_W-1:0] OP_BLTU   = 6'd37;
    localparam logic [OP_CODE_W-1:0] OP_BGEU   = 6'd38;
    localparam logic [OP_CODE_W-1:0] OP_JALR   = 6'd39;
    localparam logic [OP_CODE_W-1:0] OP_JAL    = 6'd40;

    typedef enum logic [2:0] {
        ALU,
        BRANCH,
        JUMP,
        LOAD,
        ILLEGAL
    } op_class_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        OUT
    } state_e;

    // Only the codes the controller knows how to retire get a real class;
    // everything else, including NOP, is reported as illegal.
    function automatic op_class_e op_class(input logic [OP_CODE_W-1:0] op);
        if ((op >= OP_ADDI && op <= OP_SRAI) || (op >= OP_ADD && op <= OP_AND))
            return ALU;
        else if (op >= OP_BEQ && op <= OP_BGEU)
            return BRANCH;
        else if (op == OP_JAL || op == OP_JALR)
            return JUMP;
        else if (op == OP_LB)
            return LOAD;
        else
            return ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_op_class_dec.sv
// Combinational op-code decode: class, register-write intent and whether
// the external ALU takes part in the operation.
module alu_op_class_dec
    import alu_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output op_class_e       cls,
    output logic            wb_we,
    output logic            uses_alu
);

    // Classify the op and derive the per-class control bits.
    always_comb begin
        cls      = op_class(OP_CODE_W'(op));
        wb_we    = (cls == ALU) || (cls == JUMP);
        uses_alu = (cls == ALU) || (cls == BRANCH);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a registered 1-cycle ALU: accepts one op from decode,
// runs it through EXEC/CAPT, presents the result to writeback in OUT and
// emits a one-cycle redirect for taken branches and jumps.
// Optional build macro ALU_PERF_EN adds perf_ops / perf_br retirement counters.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 6,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic [OP_W-1:0] alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] alu_imm,
    output logic [XLEN-1:0] alu_pc,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_branch,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_we,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            br_valid,
    output logic [XLEN-1:0] br_target,
    output logic            illegal,
    output logic            busy
`ifdef ALU_PERF_EN
    ,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_br
`endif
);

    state_e          state_q, state_d;
    logic            accept;

    logic [OP_W-1:0] op_p0;
    logic [XLEN-1:0] a_p0, b_p0, imm_p0, pc_p0;
    logic [RD_W-1:0] rd_p0;

    logic [XLEN-1:0] wb_data_p2, br_target_p2;
    logic [RD_W-1:0] wb_rd_p2;
    logic            wb_we_p2, illegal_p2, br_taken_p2, first_out_p2;

    op_class_e       cls;
    logic            cls_we, uses_alu;
    logic [XLEN-1:0] link_addr, rel_target, reg_target;

    alu_op_class_dec #(.OP_W(OP_W)) u_dec (
        .op       (op_p0),
        .cls      (cls),
        .wb_we    (cls_we),
        .uses_alu (uses_alu)
    );

    // Flush blocks acceptance so an op offered alongside it is not taken.
    assign in_ready = !flush && ((state_q == IDLE) || (state_q == OUT && wb_ready));
    assign accept   = in_valid && in_ready;

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = CAPT;
            CAPT:    state_d = OUT;
            OUT:     if (wb_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // State register and accept stage: operands held from accept until the next op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_p0   <= '0;
            a_p0    <= '0;
            b_p0    <= '0;
            imm_p0  <= '0;
            pc_p0   <= '0;
            rd_p0   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_p0  <= in_op;
                a_p0   <= in_rs1;
                b_p0   <= in_rs2;
                imm_p0 <= in_imm;
                pc_p0  <= in_pc;
                rd_p0  <= in_rd;
            end
        end
    end

    assign link_addr  = pc_p0 + XLEN'(4);
    assign rel_target = pc_p0 + imm_p0;
    assign reg_target = (a_p0 + imm_p0) & ~XLEN'(1);

    // Capture stage: ALU outputs are valid during CAPT and are frozen here so
    // the writeback payload stays stable however long OUT stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_p2   <= '0;
            wb_rd_p2     <= '0;
            wb_we_p2     <= 1'b0;
            illegal_p2   <= 1'b0;
            br_taken_p2  <= 1'b0;
            br_target_p2 <= '0;
            first_out_p2 <= 1'b0;
        end else begin
            first_out_p2 <= (state_q == CAPT);
            if (state_q == CAPT) begin
                wb_rd_p2   <= rd_p0;
                wb_we_p2   <= cls_we && (rd_p0 != '0);
                illegal_p2 <= (cls == ILLEGAL);
                case (cls)
                    ALU: begin
                        wb_data_p2   <= alu_result;
                        br_taken_p2  <= 1'b0;
                        br_target_p2 <= rel_target;
                    end
                    BRANCH: begin
                        wb_data_p2   <= '0;
                        br_taken_p2  <= alu_branch;
                        br_target_p2 <= rel_target;
                    end
                    JUMP: begin
                        wb_data_p2   <= link_addr;
                        br_taken_p2  <= 1'b1;
                        br_target_p2 <= (op_p0 == OP_W'(OP_JALR)) ? reg_target : rel_target;
                    end
                    LOAD: begin
                        wb_data_p2   <= a_p0 + imm_p0;
                        br_taken_p2  <= 1'b0;
                        br_target_p2 <= rel_target;
                    end
                    default: begin
                        wb_data_p2   <= '0;
                        br_taken_p2  <= 1'b0;
                        br_target_p2 <= rel_target;
                    end
                endcase
            end
        end
    end

    assign alu_op    = (state_q == EXEC && uses_alu) ? op_p0 : '0;
    assign alu_a     = a_p0;
    assign alu_b     = b_p0;
    assign alu_imm   = imm_p0;
    assign alu_pc    = pc_p0;
    assign wb_valid  = (state_q == OUT) && !flush;
    assign wb_we     = wb_we_p2;
    assign wb_rd     = wb_rd_p2;
    assign wb_data   = wb_data_p2;
    assign br_valid  = wb_valid && first_out_p2 && br_taken_p2;
    assign br_target = br_target_p2;
    assign illegal   = wb_valid && illegal_p2;
    assign busy      = (state_q != IDLE);

`ifdef ALU_PERF_EN
    // Retirement counters; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops <= '0;
            perf_br  <= '0;
        end else begin
            if (wb_valid && wb_ready) perf_ops <= perf_ops + 32'd1;
            if (br_valid)             perf_br  <= perf_br + 32'd1;
        end
    end
`endif

endmodule
